wb_lsu_ctrl: RTL and testbench

Load/store sequencer between the core's memory stage and the Wishbone data bus. It accepts one byte, halfword or word request at a byte address. It generates lane selects and lane-placed write data, and splits misaligned accesses into two bus beats. It reassembles and sign/zero-extends read data and returns a single response. Bus errors and ack timeouts are reported as a response error.

---
 rtl/wb_lsu_ctrl_pkg.sv | 28 ++
 rtl/wb_lsu_ctrl_rdalign.sv | 35 +++
 rtl/wb_lsu_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_lsu_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_lsu_ctrl_pkg.sv
// Shared definitions for the Wishbone load/store sequencer: size encodings,
// the controller state type and the size-to-lane-mask helper.
package wb_lsu_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] sizeMask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/wb_lsu_ctrl_rdalign.sv
// Reassembles load data from one or two captured bus words and extends it
// to the full register width according to access size and signedness.
module wb_lsu_ctrl_rdalign
  import wb_lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rbuf0_i,
  input  logic [XLEN-1:0] rbuf1_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [5:0]      shAmt;
  logic [XLEN-1:0] raw;
  logic            signExt;

  assign shAmt   = {1'b0, off_i, 3'b000};
  // A shift by the full width yields zero, so off=0 takes only the first word.
  assign raw     = (rbuf0_i >> shAmt) | (rbuf1_i << (6'(XLEN) - shAmt));
  assign signExt = ~unsigned_i;

  always_comb begin
    rdata_o = '0;
    case (size_i)
      SZ_B:    rdata_o = {{(XLEN-8){signExt & raw[7]}}, raw[7:0]};
      SZ_H:    rdata_o = {{(XLEN-16){signExt & raw[15]}}, raw[15:0]};
      SZ_W:    rdata_o = raw;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_lsu_ctrl.sv
// Load/store sequencer from the memory stage onto a Wishbone classic data bus,
// splitting misaligned accesses into two beats and returning one response.
module wb_lsu_ctrl
  import wb_lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [XLEN-3:0] adr_o,
  output logic [XLEN-1:0] dat_o,
  input  logic [XLEN-1:0] dat_i,
  output logic [3:0]      sel_o,
  output logic            we_o,
  output logic            cyc_o,
  output logic            stb_o,
  input  logic            ack_i,
  input  logic            err_i
);

  localparam int             CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            reqWe_q, reqWe_d;
  logic [1:0]      reqSize_q, reqSize_d;
  logic            reqUnsigned_q, reqUnsigned_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-3:0] wordAddr_q, wordAddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            split_q, split_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rbuf0_q, rbuf0_d;
  logic [XLEN-1:0] rbuf1_q, rbuf1_d;
  logic [XLEN-3:0] adr_q, adr_d;
  logic [XLEN-1:0] dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            busWe_q, busWe_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;

  logic [3:0]      reqMask;
  logic [7:0]      reqLanes;
  logic [XLEN-1:0] beat0Data;
  logic [3:0]      beat1Sel;
  logic [XLEN-1:0] beat1Data;
  logic [XLEN-1:0] rdAligned;
  logic            busDone;

  // Lanes that spill past byte 3 mark an access that needs a second beat.
  assign reqMask   = sizeMask(req_size_i);
  assign reqLanes  = {4'b0000, reqMask} << req_addr_i[1:0];
  assign beat0Data = req_wdata_i << {req_addr_i[1:0], 3'b000};
  assign beat1Sel  = sizeMask(reqSize_q) >> (3'd4 - {1'b0, off_q});
  assign beat1Data = wdata_q >> (6'(XLEN) - {1'b0, off_q, 3'b000});

  wb_lsu_ctrl_rdalign #(
    .XLEN(XLEN)
  ) u_rdalign (
    .rbuf0_i    (rbuf0_q),
    .rbuf1_i    (rbuf1_q),
    .off_i      (off_q),
    .size_i     (reqSize_q),
    .unsigned_i (reqUnsigned_q),
    .rdata_o    (rdAligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      reqWe_q       <= 1'b0;
      reqSize_q     <= SZ_B;
      reqUnsigned_q <= 1'b0;
      off_q         <= 2'b00;
      wordAddr_q    <= '0;
      wdata_q       <= '0;
      split_q       <= 1'b0;
      err_q         <= 1'b0;
      rbuf0_q       <= '0;
      rbuf1_q       <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= 4'b0000;
      busWe_q       <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reqWe_q       <= reqWe_d;
      reqSize_q     <= reqSize_d;
      reqUnsigned_q <= reqUnsigned_d;
      off_q         <= off_d;
      wordAddr_q    <= wordAddr_d;
      wdata_q       <= wdata_d;
      split_q       <= split_d;
      err_q         <= err_d;
      rbuf0_q       <= rbuf0_d;
      rbuf1_q       <= rbuf1_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      busWe_q       <= busWe_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reqWe_d       = reqWe_q;
    reqSize_d     = reqSize_q;
    reqUnsigned_d = reqUnsigned_q;
    off_d         = off_q;
    wordAddr_d    = wordAddr_q;
    wdata_d       = wdata_q;
    split_d       = split_q;
    err_d         = err_q;
    rbuf0_d       = rbuf0_q;
    rbuf1_d       = rbuf1_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    busWe_d       = busWe_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    busDone       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          reqWe_d       = req_we_i;
          reqSize_d     = req_size_i;
          reqUnsigned_d = req_unsigned_i;
          off_d         = req_addr_i[1:0];
          wordAddr_d    = req_addr_i[XLEN-1:2];
          wdata_d       = req_wdata_i;
          split_d       = |reqLanes[7:4];
          err_d         = 1'b0;
          rbuf0_d       = '0;
          rbuf1_d       = '0;
          cnt_d         = '0;
          if (req_size_i == SZ_X) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BEAT0;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            busWe_d = req_we_i;
            adr_d   = req_addr_i[XLEN-1:2];
            sel_d   = reqLanes[3:0];
            dat_d   = beat0Data;
          end
        end
      end
      BEAT0, BEAT1: begin
        // err has priority over a simultaneous ack.
        if (err_i) begin
          err_d   = 1'b1;
          busDone = 1'b1;
        end else if (ack_i) begin
          if (state_q == BEAT0) begin
            rbuf0_d = dat_i;
            if (split_q) begin
              state_d = BEAT1;
              cnt_d   = '0;
              adr_d   = wordAddr_q + 1'b1;
              sel_d   = beat1Sel;
              dat_d   = beat1Data;
            end else begin
              busDone = 1'b1;
            end
          end else begin
            rbuf1_d = dat_i;
            busDone = 1'b1;
          end
        end else if (cnt_q == TMAX) begin
          err_d   = 1'b1;
          busDone = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (busDone) begin
      state_d = RESP;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      busWe_d = 1'b0;
      adr_d   = '0;
      sel_d   = 4'b0000;
      dat_d   = '0;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !reqWe_q) ? rdAligned : '0;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = sel_q;
  assign we_o        = busWe_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;

endmodule

// File: tb/tb_wb_lsu_ctrl.sv
// Directed, table-driven bench for wb_lsu_ctrl with a short ack timeout so
// the abort path is reachable in a few cycles.
module tb_wb_lsu_ctrl;

  localparam int TMO = 4;

  // Bus termination modes for a beat
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [29:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic        ack_i = 1'b0;
  logic        err_i = 1'b0;

  int compCount = 0;
  int missCount = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          mode0;
    logic [31:0] rd0;
    int          mode1;
    logic [31:0] rd1;
    logic [29:0] adr0;
    logic [3:0]  sel0;
    logic [31:0] dat0;
    logic        split;
    logic [29:0] adr1;
    logic [3:0]  sel1;
    logic [31:0] dat1;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  wb_lsu_ctrl #(
    .XLEN    (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .adr_o          (adr_o),
    .dat_o          (dat_o),
    .dat_i          (dat_i),
    .sel_o          (sel_o),
    .we_o           (we_o),
    .cyc_o          (cyc_o),
    .stb_o          (stb_o),
    .ack_i          (ack_i),
    .err_i          (err_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int mode0,
                                 input logic [31:0] rd0, input int mode1,
                                 input logic [31:0] rd1, input logic [29:0] adr0,
                                 input logic [3:0] sel0, input logic [31:0] dat0,
                                 input logic split, input logic [29:0] adr1,
                                 input logic [3:0] sel1, input logic [31:0] dat1,
                                 input logic [31:0] rdata, input logic err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.mode0 = mode0; v.rd0 = rd0; v.mode1 = mode1; v.rd1 = rd1;
    v.adr0 = adr0; v.sel0 = sel0; v.dat0 = dat0; v.split = split;
    v.adr1 = adr1; v.sel1 = sel1; v.dat1 = dat1; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic driveTerm(input int mode, input logic [31:0] data);
    dat_i = data;
    ack_i = (mode == M_ACK) || (mode == M_BOTH);
    err_i = (mode == M_ERR) || (mode == M_BOTH);
  endtask

  task automatic clearTerm();
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
  endtask

  // Runs one request cycle-exactly, checking bus beats and the response.
  task automatic applyStimulus(input vec_t v);
    int stbCycles;
    @(negedge clk);
    checkOutput({v.name, ".ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = v.we;
    req_size_i     = v.size;
    req_unsigned_i = v.uns;
    req_addr_i     = v.addr;
    req_wdata_i    = v.wdata;
    @(negedge clk);
    req_valid_i = 1'b0;
    if (v.size == 2'b11) begin
      checkOutput({v.name, ".cyc"}, 32'(cyc_o), 32'd0);
    end else begin
      checkOutput({v.name, ".cyc0"}, 32'(cyc_o), 32'd1);
      checkOutput({v.name, ".stb0"}, 32'(stb_o), 32'd1);
      checkOutput({v.name, ".we"}, 32'(we_o), 32'(v.we));
      checkOutput({v.name, ".adr0"}, 32'(adr_o), 32'(v.adr0));
      checkOutput({v.name, ".sel0"}, 32'(sel_o), 32'(v.sel0));
      checkOutput({v.name, ".dat0"}, dat_o, v.dat0);
      if (v.mode0 == M_NONE) begin
        stbCycles = 1;
        for (int i = 0; i < 20 && stb_o; i++) begin
          @(negedge clk);
          if (stb_o) stbCycles++;
        end
        checkOutput({v.name, ".stbCycles"}, 32'(stbCycles), 32'(TMO + 1));
      end else begin
        driveTerm(v.mode0, v.rd0);
        @(negedge clk);
        clearTerm();
        if (v.split && v.mode0 == M_ACK) begin
          checkOutput({v.name, ".cyc1"}, 32'(cyc_o), 32'd1);
          checkOutput({v.name, ".stb1"}, 32'(stb_o), 32'd1);
          checkOutput({v.name, ".adr1"}, 32'(adr_o), 32'(v.adr1));
          checkOutput({v.name, ".sel1"}, 32'(sel_o), 32'(v.sel1));
          checkOutput({v.name, ".dat1"}, dat_o, v.dat1);
          driveTerm(v.mode1, v.rd1);
          @(negedge clk);
          clearTerm();
        end
      end
      checkOutput({v.name, ".cycEnd"}, 32'(cyc_o), 32'd0);
    end
    checkOutput({v.name, ".rspValid"}, 32'(rsp_valid_o), 32'd1);
    checkOutput({v.name, ".rspErr"}, 32'(rsp_err_o), 32'(v.err));
    checkOutput({v.name, ".rspData"}, rsp_rdata_o, v.rdata);
    @(negedge clk);
    checkOutput({v.name, ".rspPulse"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    //            name     we    sz     uns   addr          wdata         m0      rd0           m1      rd1           adr0          sel0     dat0          split adr1          sel1     dat1          rdata         err
    vecs.push_back(mkVec("stB",   1'b1, 2'b00, 1'b0, 32'h0000_1002, 32'h0000_00A5, M_ACK,  32'h0,        M_ACK, 32'h0,        30'h400,      4'b0100, 32'h00A5_0000, 1'b0, 30'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mkVec("ldHs",  1'b0, 2'b01, 1'b0, 32'h0000_2003, 32'h0,        M_ACK,  32'h8012_3456, M_ACK, 32'hABCD_EFFF, 30'h800,     4'b1000, 32'h0,        1'b1, 30'h801,      4'b0001, 32'h0,        32'hFFFF_FF80, 1'b0));
    vecs.push_back(mkVec("ldHu",  1'b0, 2'b01, 1'b1, 32'h0000_2003, 32'h0,        M_ACK,  32'h8012_3456, M_ACK, 32'hABCD_EFFF, 30'h800,     4'b1000, 32'h0,        1'b1, 30'h801,      4'b0001, 32'h0,        32'h0000_FF80, 1'b0));
    vecs.push_back(mkVec("stWw",  1'b1, 2'b10, 1'b0, 32'h0FFF_FFFD, 32'h1122_3344, M_ACK, 32'h0,        M_ACK, 32'h0,        30'h03FF_FFFF, 4'b1110, 32'h2233_4400, 1'b1, 30'h0400_0000, 4'b0001, 32'h0000_0011, 32'h0,       1'b0));
    vecs.push_back(mkVec("ldW",   1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        M_ACK,  32'hDEAD_BEEF, M_ACK, 32'h0,        30'h40,       4'b1111, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mkVec("ldBs3", 1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0,        M_ACK,  32'h8500_0000, M_ACK, 32'h0,        30'h1,        4'b1000, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'hFFFF_FF85, 1'b0));
    vecs.push_back(mkVec("ldBu1", 1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0,        M_ACK,  32'h0000_F200, M_ACK, 32'h0,        30'h1,        4'b0010, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'h0000_00F2, 1'b0));
    vecs.push_back(mkVec("ldHs2", 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        M_ACK,  32'h7FFE_0000, M_ACK, 32'h0,        30'h4,        4'b1100, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'h0000_7FFE, 1'b0));
    vecs.push_back(mkVec("stH1",  1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'hCAFE_BEEF, M_ACK, 32'h0,        M_ACK, 32'h0,        30'h8,        4'b0110, 32'hFEBE_EF00, 1'b0, 30'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mkVec("ldWs2", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        M_ACK,  32'h3344_1111, M_ACK, 32'hAAAA_1122, 30'h1,       4'b1100, 32'h0,        1'b1, 30'h2,        4'b0011, 32'h0,        32'h1122_3344, 1'b0));
    vecs.push_back(mkVec("illeg", 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        M_ACK,  32'h0,        M_ACK, 32'h0,        30'h0,        4'b0000, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkVec("tmo",   1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0,        M_NONE, 32'h0,        M_ACK, 32'h0,        30'h20,       4'b1111, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkVec("err0s", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        M_ERR,  32'h1234_5678, M_ACK, 32'h0,        30'h40,       4'b1110, 32'h0,        1'b1, 30'h41,       4'b0001, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkVec("both",  1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0,        M_BOTH, 32'h5555_AAAA, M_ACK, 32'h0,        30'h11,       4'b1111, 32'h0,        1'b0, 30'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mkVec("err1",  1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        M_ACK,  32'hFF00_0000, M_ERR, 32'h0000_00FF, 30'h0,       4'b1000, 32'h0,        1'b1, 30'h1,        4'b0001, 32'h0,        32'h0,        1'b1));

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst.rspValid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst.rspErr", 32'(rsp_err_o), 32'd0);
    checkOutput("rst.rspData", rsp_rdata_o, 32'h0);
    checkOutput("rst.cyc", 32'(cyc_o), 32'd0);
    checkOutput("rst.stb", 32'(stb_o), 32'd0);
    checkOutput("rst.we", 32'(we_o), 32'd0);
    checkOutput("rst.adr", 32'(adr_o), 32'h0);
    checkOutput("rst.sel", 32'(sel_o), 32'h0);
    checkOutput("rst.dat", dat_o, 32'h0);
    rst_i = 1'b0;

    // Stray termination while idle must be ignored
    @(negedge clk);
    driveTerm(M_BOTH, 32'hFFFF_FFFF);
    @(negedge clk);
    clearTerm();
    checkOutput("idleTerm.rspValid", 32'(rsp_valid_o), 32'd0);
    checkOutput("idleTerm.ready", 32'(req_ready_o), 32'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while the second beat of a split word load is outstanding
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_size_i  = 2'b10;
    req_unsigned_i = 1'b0;
    req_addr_i  = 32'h0000_0001;
    @(negedge clk);
    req_valid_i = 1'b0;
    driveTerm(M_ACK, 32'h0102_0304);
    @(negedge clk);
    clearTerm();
    checkOutput("rstMid.cyc1", 32'(cyc_o), 32'd1);
    checkOutput("rstMid.sel1", 32'(sel_o), 32'b0001);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("rstMid.cyc", 32'(cyc_o), 32'd0);
    checkOutput("rstMid.stb", 32'(stb_o), 32'd0);
    checkOutput("rstMid.rspValid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("rstMid.noRsp", 32'(rsp_valid_o), 32'd0);
    applyStimulus(vecs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", compCount, missCount);
    $finish;
  end

endmodule
